// File: rtl/vga_sync_gen.sv
// VGA timing source: column/row counters, stage-0 decodes, registered
// sync/colour outputs, frame counter and periodic game tick.
module vga_sync_gen #(
  parameter int unsigned TOTAL_COLS      = 800,
  parameter int unsigned TOTAL_ROWS      = 525,
  parameter int unsigned ACTIVE_COLS     = 640,
  parameter int unsigned ACTIVE_ROWS     = 480,
  parameter int unsigned H_FRONT_PORCH   = 16,
  parameter int unsigned H_SYNC_WIDTH    = 96,
  parameter int unsigned V_FRONT_PORCH   = 10,
  parameter int unsigned V_SYNC_WIDTH    = 2,
  parameter int unsigned FRAMES_PER_TICK = 30
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  input  logic [3:0] i_Red_Video,
  input  logic [3:0] i_Grn_Video,
  input  logic [3:0] i_Blu_Video,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [3:0] o_Red_Video,
  output logic [3:0] o_Grn_Video,
  output logic [3:0] o_Blu_Video,
  output logic [7:0] o_Frame_Count,
  output logic       o_Game_Tick
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned FC_W   = 8;
  localparam int unsigned CLR_W  = 4;
  localparam int unsigned TICK_W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;

  localparam logic [CNT_W-1:0] COL_LAST     = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST     = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] ACT_COL_LAST = CNT_W'(ACTIVE_COLS - 1);
  localparam logic [CNT_W-1:0] ACT_ROW_LAST = CNT_W'(ACTIVE_ROWS - 1);
  localparam logic [CNT_W-1:0] HS_FIRST     = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CNT_W-1:0] HS_LAST      = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [CNT_W-1:0] VS_FIRST     = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [CNT_W-1:0] VS_LAST      = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(FRAMES_PER_TICK - 1);

  // Counters are 10 bits wide; larger frame geometries cannot be represented.
  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_geometry
    $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS must not exceed 1024");
  end
  if (FRAMES_PER_TICK < 1) begin : g_bad_tick
    $error("vga_sync_gen: FRAMES_PER_TICK must be at least 1");
  end

  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [CLR_W-1:0]  red_q, red_d;
  logic [CLR_W-1:0]  grn_q, grn_d;
  logic [CLR_W-1:0]  blu_q, blu_d;

  logic active_c;
  logic frame_start_c;
  logic game_tick_c;
  logic hsync_zone_c;
  logic vsync_zone_c;

  // Stage-0 decodes of the current count.
  always_comb begin
    active_c      = (col_q <= ACT_COL_LAST) && (row_q <= ACT_ROW_LAST);
    frame_start_c = i_Enable && (col_q == '0) && (row_q == '0);
    game_tick_c   = frame_start_c && (tick_cnt_q == TICK_LAST);
    hsync_zone_c  = (col_q >= HS_FIRST) && (col_q <= HS_LAST);
    vsync_zone_c  = (row_q >= VS_FIRST) && (row_q <= VS_LAST);
  end

  // Next-state: raster advance, frame/tick counting, stage-1 sync and colour.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    frame_cnt_d = frame_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    hsync_d     = 1'b1;
    vsync_d     = 1'b1;
    red_d       = '0;
    grn_d       = '0;
    blu_d       = '0;

    if (!i_Enable) begin
      col_d = '0;
      row_d = '0;
    end else begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d       = '0;
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end else begin
          row_d = row_q + CNT_W'(1);
        end
      end else begin
        col_d = col_q + CNT_W'(1);
      end

      hsync_d = !hsync_zone_c;
      vsync_d = !vsync_zone_c;
      if (active_c) begin
        red_d = i_Red_Video;
        grn_d = i_Grn_Video;
        blu_d = i_Blu_Video;
      end
    end

    if (game_tick_c) begin
      tick_cnt_d = '0;
    end else if (frame_start_c) begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_q       <= '0;
      row_q       <= '0;
      frame_cnt_q <= '0;
      tick_cnt_q  <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      red_q       <= '0;
      grn_q       <= '0;
      blu_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      frame_cnt_q <= frame_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      blu_q       <= blu_d;
    end
  end

  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Active      = active_c;
  assign o_Frame_Start = frame_start_c;
  assign o_Game_Tick   = game_tick_c;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Red_Video   = red_q;
  assign o_Grn_Video   = grn_q;
  assign o_Blu_Video   = blu_q;
  assign o_Frame_Count = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-geometry instance exercised over ten
// frames plus enable and reset events, and a default-geometry instance
// checked for horizontal timing on the first lines.
module tb_vga_sync_gen;

  // Reduced geometry: sync cols 14..16, sync rows 9..10, frame = 240 clocks.
  localparam int unsigned TC    = 20;
  localparam int unsigned TR    = 12;
  localparam int unsigned AC    = 12;
  localparam int unsigned AR    = 8;
  localparam int unsigned FRAME = TC * TR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] red_in, grn_in, blu_in;

  logic [9:0] col, row;
  logic       active, frame_start, hsync, vsync, game_tick;
  logic [3:0] red, grn, blu;
  logic [7:0] frame_count;

  logic [9:0] d_col, d_row;
  logic       d_active, d_frame_start, d_hsync, d_vsync, d_game_tick;
  logic [3:0] d_red, d_grn, d_blu;
  logic [7:0] d_frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2),
    .FRAMES_PER_TICK(3)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
    .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
    .o_Col_Count(col), .o_Row_Count(row), .o_Active(active),
    .o_Frame_Start(frame_start), .o_HSync(hsync), .o_VSync(vsync),
    .o_Red_Video(red), .o_Grn_Video(grn), .o_Blu_Video(blu),
    .o_Frame_Count(frame_count), .o_Game_Tick(game_tick)
  );

  vga_sync_gen dut_d (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
    .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
    .o_Col_Count(d_col), .o_Row_Count(d_row), .o_Active(d_active),
    .o_Frame_Start(d_frame_start), .o_HSync(d_hsync), .o_VSync(d_vsync),
    .o_Red_Video(d_red), .o_Grn_Video(d_grn), .o_Blu_Video(d_blu),
    .o_Frame_Count(d_frame_count), .o_Game_Tick(d_game_tick)
  );

  // Count one comparison and report it if observed differs from expected.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Checks for cycle t after reset release (enable held high since release).
  task automatic check_cycle(input int t);
    int ec, er, f, pc, pr, dpc;
    logic fs, vid;
    ec = t % TC;
    er = (t / TC) % TR;
    f  = t / FRAME;
    fs = (ec == 0) && (er == 0);
    check("col", 32'(col), 32'(ec));
    check("row", 32'(row), 32'(er));
    check("active", 32'(active), 32'((ec < AC) && (er < AR)));
    check("frame_start", 32'(frame_start), 32'(fs));
    check("game_tick", 32'(game_tick), 32'(fs && (f % 3 == 2)));
    check("frame_count", 32'(frame_count), 32'(f % 256));
    if (t == 0) begin
      check("hsync0", 32'(hsync), 32'd1);
      check("vsync0", 32'(vsync), 32'd1);
      check("video0", 32'({red, grn, blu}), 32'd0);
      check("d_hsync0", 32'(d_hsync), 32'd1);
    end else begin
      pc  = (t - 1) % TC;
      pr  = ((t - 1) / TC) % TR;
      vid = (pc < AC) && (pr < AR);
      check("hsync", 32'(hsync), 32'(!(pc >= 14 && pc <= 16)));
      check("vsync", 32'(vsync), 32'(!(pr >= 9 && pr <= 10)));
      check("video", 32'({red, grn, blu}), vid ? 32'h0FA5 : 32'd0);
      dpc = (t - 1) % 800;
      check("d_hsync", 32'(d_hsync), 32'(!(dpc >= 656 && dpc <= 751)));
    end
    check("d_col", 32'(d_col), 32'(t % 800));
    check("d_row", 32'(d_row), 32'(t / 800));
    check("d_frame_start", 32'(d_frame_start), 32'(t == 0));
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    red_in = 4'hF;
    grn_in = 4'hA;
    blu_in = 4'h5;

    repeat (3) @(posedge clk);
    #2;
    check("rst_col", 32'(col), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_video", 32'({red, grn, blu}), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_game_tick", 32'(game_tick), 32'd0);

    // Release and run ten frames plus a few lines; stop at col 5, row 3.
    rst_n = 1'b1;
    #1;
    for (int t = 0; ; t++) begin
      check_cycle(t);
      if (t == 2465) break;
      @(posedge clk);
      #2;
    end

    // Drop enable at col 5, row 3 of frame 10 and hold it low.
    en = 1'b0;
    #1;
    check("dis_frame_start", 32'(frame_start), 32'd0);
    check("dis_col_now", 32'(col), 32'd5);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      check("dis_col", 32'(col), 32'd0);
      check("dis_row", 32'(row), 32'd0);
      check("dis_hsync", 32'(hsync), 32'd1);
      check("dis_vsync", 32'(vsync), 32'd1);
      check("dis_video", 32'({red, grn, blu}), 32'd0);
      check("dis_frame_start", 32'(frame_start), 32'd0);
      check("dis_game_tick", 32'(game_tick), 32'd0);
      check("dis_frame_count", 32'(frame_count), 32'd10);
      check("dis_d_col", 32'(d_col), 32'd0);
      check("dis_d_hsync", 32'(d_hsync), 32'd1);
    end

    // Re-enable: twelfth frame start, tick counter at 2 -> game tick.
    en = 1'b1;
    #1;
    check("ren_frame_start", 32'(frame_start), 32'd1);
    check("ren_game_tick", 32'(game_tick), 32'd1);
    check("ren_frame_count", 32'(frame_count), 32'd10);
    check("ren_d_frame_start", 32'(d_frame_start), 32'd1);

    // Advance into the HSync pulse, then reset asynchronously.
    repeat (15) @(posedge clk);
    #2;
    check("pre_col", 32'(col), 32'd15);
    check("pre_hsync", 32'(hsync), 32'd0);
    check("pre_frame_start", 32'(frame_start), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hsync", 32'(hsync), 32'd1);
    check("arst_col", 32'(col), 32'd0);
    check("arst_row", 32'(row), 32'd0);
    check("arst_frame_count", 32'(frame_count), 32'd0);
    check("arst_game_tick", 32'(game_tick), 32'd0);
    check("arst_video", 32'({red, grn, blu}), 32'd0);
    check("arst_d_col", 32'(d_col), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Video timing source for the VGA interface: generates the HSync/VSync pulse pair and the column/row counts that the downstream sync-to-count and game/render logic consume. It registers the renderer's colour back in so that sync and video leave the block phase-aligned, with blanking enforced outside the active area. It also derives a frame counter and a periodic game-tick pulse from frame boundaries, which replaces the free-running game clock.

Parameters:
TOTAL_COLS, 800, pixel clocks per line
TOTAL_ROWS, 525, lines per frame
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
H_FRONT_PORCH, 16, clocks between end of active and HSync assertion
H_SYNC_WIDTH, 96, HSync low width in clocks
V_FRONT_PORCH, 10, lines between end of active and VSync assertion
V_SYNC_WIDTH, 2, VSync low width in lines
FRAMES_PER_TICK, 30, frames per o_Game_Tick pulse (>=1)

Ports:
i_Clk  in  1  pixel clock (25.175 MHz nominal)
i_Rst_L  in  1  asynchronous, active-low reset
i_Enable  in  1  run enable; low = counters held at 0
i_Red_Video  in  4  renderer red for the current o_Col_Count/o_Row_Count
i_Grn_Video  in  4  renderer green, same timing
i_Blu_Video  in  4  renderer blue, same timing
o_Col_Count  out  10  current column, stage 0
o_Row_Count  out  10  current row, stage 0
o_Active  out  1  stage 0: col<ACTIVE_COLS and row<ACTIVE_ROWS
o_Frame_Start  out  1  stage 0 one-clock pulse at col=0,row=0
o_HSync  out  1  stage 1, active low
o_VSync  out  1  stage 1, active low
o_Red_Video  out  4  stage 1, blanked colour
o_Grn_Video  out  4  stage 1, blanked colour
o_Blu_Video  out  4  stage 1, blanked colour
o_Frame_Count  out  8  completed frames, wraps 255->0
o_Game_Tick  out  1  one-clock pulse every FRAMES_PER_TICK frames

Behaviour:
- Clocking and reset: one clock (i_Clk). Reset is asynchronous and active-low (i_Rst_L). Reset values: col=0, row=0, o_HSync=1, o_VSync=1, colours=0, o_Frame_Count=0, tick counter=0, o_Game_Tick=0.
- Stage 0 outputs (o_Active, o_Frame_Start) are combinational from the count registers. They and o_Col_Count/o_Row_Count are valid in the same cycle the renderer must answer.
- Counting (i_Enable=1): col increments every clock. At col=TOTAL_COLS-1, col wraps to 0 and row increments. At row=TOTAL_ROWS-1 with col=TOTAL_COLS-1, row wraps to 0 and o_Frame_Count increments mod 256.
- Horizontal phases, derived from col: ACTIVE [0, ACTIVE_COLS-1]; FRONT; SYNC [ACTIVE_COLS+H_FRONT_PORCH, +H_SYNC_WIDTH-1], defaults 656..751; BACK up to TOTAL_COLS-1.
- Vertical phases are the same with row and V_* parameters. VSync-low rows are 490..491 by default, for the full width of each such line.
- Stage 1 (latency 1 clock): o_HSync/o_VSync are the registered phase decodes of the stage-0 count. o_*_Video are the registered i_*_Video when stage-0 o_Active=1, otherwise 0.
- Frame start and game tick:
  - o_Frame_Start is asserted when col=0, row=0 and i_Enable=1, including the first cycle after reset release.
  - The tick counter increments on each o_Frame_Start.
  - When o_Frame_Start occurs with tick counter = FRAMES_PER_TICK-1, o_Game_Tick pulses in that same cycle (combinational, stage 0) and the tick counter clears.
  - With FRAMES_PER_TICK=1, every frame start ticks.
- i_Enable=0:
  - col/row are forced to 0 synchronously and held there.
  - Stage-0 pulses are low; stage 1 drives syncs high and colours 0 on the next clock.
  - o_Frame_Count and the tick counter hold.
  - When i_Enable returns to 1, counting resumes from col=0,row=0 with o_Frame_Start asserted in that cycle.
- Reset asserted mid-frame returns all state to reset values immediately, independent of the clock.
- Widths: counts are 10 bits. A parameter set with TOTAL_COLS or TOTAL_ROWS >1024 is unsupported; a simulation assertion flags it at elaboration.

Test Plan:
1. Reset release, enable=1, defaults: o_Frame_Start=1 at clock 0. o_HSync first falls at clock 657 (stage-0 col 656) and stays low exactly 96 clocks. Line period is 800 clocks.
2. Run one full frame: o_VSync is low for exactly 1600 clocks, beginning 1 clock after row 490/col 0. o_Frame_Count goes 0->1 at clock 420000.
3. Drive i_*_Video=4'hF constantly: outputs are F for stage-0 cols 0..639 of rows 0..479 (delayed 1 clock) and 0 at col 640..799 and in rows 480..524.
4. FRAMES_PER_TICK=3: o_Game_Tick pulses at frame starts 3, 6, 9 (clocks 840000, 2100000, 3360000 from release), one clock each, and never at frame starts 1, 2, 4 or 5.
5. Deassert i_Enable at col=300,row=100 for 10 clocks: counts read 0/0 from the next clock, syncs high and colours 0. On re-enable, o_Frame_Start=1 and o_Frame_Count is unchanged.
6. Assert i_Rst_L=0 asynchronously mid-HSync (col 700): o_HSync=1 and counts 0 before the next clock edge. Frame and tick counters are 0.
